// File: rtl/wash_bay_scheduler.sv
// wash_bay_scheduler: round-robin arbiter sharing one wash machine controller
// among NUM_USERS coin stations. Grants one station, feeds the controller its
// coin/double-wash inputs, and holds the grant until wash_done returns.
module wash_bay_scheduler #(
  parameter int unsigned NUM_USERS   = 4,
  parameter int unsigned COIN_CYCLES = 2,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8,
  localparam int unsigned ID_W       = $clog2(NUM_USERS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_USERS-1:0] req,
  input  logic [NUM_USERS-1:0] dbl_req,
  input  logic                 wash_done_in,
  output logic [NUM_USERS-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 coin_out,
  output logic                 double_wash_out,
  output logic                 busy,
  output logic                 served,
  output logic                 fault,
  output logic [CNT_W-1:0]     served_cnt,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0]     COIN_N    = CNT_W'(COIN_CYCLES);
  localparam logic [CNT_W-1:0]     COIN_LAST = CNT_W'(COIN_CYCLES - 1);
  localparam logic [CNT_W-1:0]     ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [ID_W-1:0]      ID_MAX    = ID_W'(NUM_USERS - 1);
  localparam logic [NUM_USERS-1:0] ONE_HOT0  = NUM_USERS'(1);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] ld_cnt;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;
  logic             timeout;

  // Round-robin search starting just after the last served station.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = last;
    for (int unsigned i = 0; i < NUM_USERS; i++) begin
      cand = (cand == ID_MAX) ? '0 : cand + ID_W'(1);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Next-state decode; the RUN handoff takes precedence over the ACK timeout.
  always_comb begin
    nxt_state = cur_state;
    timeout   = 1'b0;
    case (cur_state)
      S_IDLE: if (pick_valid) nxt_state = S_LOAD;
      S_LOAD: begin
        if (ld_cnt >= COIN_LAST && !wash_done_in) begin
          nxt_state = S_RUN;
        end else if (ld_cnt == ACK_LAST && wash_done_in) begin
          nxt_state = S_IDLE;
          timeout   = 1'b1;
        end
      end
      S_RUN:  if (wash_done_in) nxt_state = S_DONE;
      S_DONE: nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) cur_state <= S_IDLE;
    else     cur_state <= nxt_state;
  end

  // Grant, counters and pulse registers; served/fault are set on the
  // transition edge so they are visible in DONE / the first IDLE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant           <= '0;
      grant_id        <= '0;
      double_wash_out <= 1'b0;
      ld_cnt          <= '0;
      served          <= 1'b0;
      fault           <= 1'b0;
      served_cnt      <= '0;
      last            <= ID_MAX;
    end else begin
      served <= 1'b0;
      fault  <= 1'b0;
      case (cur_state)
        S_IDLE: begin
          if (pick_valid) begin
            grant           <= ONE_HOT0 << pick_id;
            grant_id        <= pick_id;
            double_wash_out <= dbl_req[pick_id];
            ld_cnt          <= '0;
          end
        end
        S_LOAD: begin
          ld_cnt <= ld_cnt + CNT_W'(1);
          if (timeout) begin
            fault           <= 1'b1;
            last            <= grant_id;
            grant           <= '0;
            grant_id        <= '0;
            double_wash_out <= 1'b0;
          end
        end
        S_RUN: begin
          if (wash_done_in) begin
            served     <= 1'b1;
            served_cnt <= served_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          last            <= grant_id;
          grant           <= '0;
          grant_id        <= '0;
          double_wash_out <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    coin_out = (cur_state == S_LOAD) && (ld_cnt < COIN_N);
    busy     = (cur_state != S_IDLE);
    state    = cur_state;
  end

endmodule

// File: tb/tb_wash_bay_scheduler.sv
// Directed scoreboard bench for wash_bay_scheduler (4 stations, 2 coin cycles,
// 16-cycle ACK timeout, 8-bit served counter).
module tb_wash_bay_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] dbl_req;
  logic       wash_done_in;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       coin_out;
  logic       double_wash_out;
  logic       busy;
  logic       served;
  logic       fault;
  logic [7:0] served_cnt;
  logic [1:0] state;

  always #5 clk = ~clk;

  wash_bay_scheduler #(
    .NUM_USERS  (4),
    .COIN_CYCLES(2),
    .ACK_TIMEOUT(16),
    .CNT_W      (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .dbl_req        (dbl_req),
    .wash_done_in   (wash_done_in),
    .grant          (grant),
    .grant_id       (grant_id),
    .coin_out       (coin_out),
    .double_wash_out(double_wash_out),
    .busy           (busy),
    .served         (served),
    .fault          (fault),
    .served_cnt     (served_cnt),
    .state          (state)
  );

  typedef struct {
    logic [3:0] grant;
    logic [1:0] id;
    logic       dbl;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] m_last;
  logic [7:0] m_cnt;
  logic [1:0] cur_id;
  exp_t       cur_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first requester after the last served station.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    logic [1:0] c;
    c = last;
    for (int i = 0; i < 4; i++) begin
      c = c + 2'd1;
      if (r[c]) return c;
    end
    return 2'd0;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_gid"},   32'(grant_id), 32'd0);
    check({tag, "_coin"},  32'(coin_out), 32'd0);
    check({tag, "_dbl"},   32'(double_wash_out), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_served"},32'(served), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
  endtask

  task automatic request(input logic [3:0] req_v, input logic [3:0] dbl_v);
    exp_t e;
    logic [1:0] id;
    req     = req_v;
    dbl_req = dbl_v;
    id      = rr_pick(m_last, req_v);
    e.id    = id;
    e.grant = 4'b0001 << id;
    e.dbl   = dbl_v[id];
    exp_q.push_back(e);
  endtask

  // Waits a bounded number of cycles for a grant, then pops and compares.
  task automatic wait_grant();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      if (grant !== 4'b0000) got = 1'b1;
    end
    check("grant_seen", 32'(got), 32'd1);
    check("q_size", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      cur_exp = exp_q.pop_front();
      cur_id  = cur_exp.id;
      check("grant",    32'(grant), 32'(cur_exp.grant));
      check("grant_id", 32'(grant_id), 32'(cur_exp.id));
      check("dbl_out",  32'(double_wash_out), 32'(cur_exp.dbl));
      check("load_st",  32'(state), 32'd1);
      check("coin1",    32'(coin_out), 32'd1);
      check("busy",     32'(busy), 32'd1);
    end
  endtask

  task automatic begin_wash(input logic [3:0] req_v, input logic [3:0] dbl_v, input bit keep);
    request(req_v, dbl_v);
    wait_grant();
    if (!keep) req = 4'b0000;
    @(negedge clk);
    check("load2_st", 32'(state), 32'd1);
    check("coin2",    32'(coin_out), 32'd1);
    @(negedge clk);
    check("run_st",    32'(state), 32'd2);
    check("run_coin",  32'(coin_out), 32'd0);
    check("run_grant", 32'(grant), 32'(cur_exp.grant));
    check("run_dbl",   32'(double_wash_out), 32'(cur_exp.dbl));
  endtask

  task automatic finish_wash(input int n);
    repeat (n) begin
      @(negedge clk);
      check("run_hold", 32'(state), 32'd2);
      check("run_hold_grant", 32'(grant), 32'(cur_exp.grant));
    end
    wash_done_in = 1'b1;
    @(negedge clk);
    wash_done_in = 1'b0;
    m_cnt = m_cnt + 8'd1;
    check("done_st",     32'(state), 32'd3);
    check("served",      32'(served), 32'd1);
    check("served_cnt",  32'(served_cnt), 32'(m_cnt));
    check("done_grant",  32'(grant), 32'(cur_exp.grant));
    check("done_busy",   32'(busy), 32'd1);
    @(negedge clk);
    check_quiet("post_done");
    m_last = cur_id;
  endtask

  task automatic fault_wash(input logic [3:0] req_v);
    wash_done_in = 1'b1;
    request(req_v, 4'b0000);
    wait_grant();
    req = 4'b0000;
    for (int k = 1; k <= 16; k++) begin
      if (k > 1) @(negedge clk);
      check("to_load_st", 32'(state), 32'd1);
      check("to_coin",    32'(coin_out), (k <= 2) ? 32'd1 : 32'd0);
      check("to_fault0",  32'(fault), 32'd0);
    end
    @(negedge clk);
    wash_done_in = 1'b0;
    check("to_fault",  32'(fault), 32'd1);
    check("to_idle",   32'(state), 32'd0);
    check("to_grant",  32'(grant), 32'd0);
    check("to_cnt",    32'(served_cnt), 32'(m_cnt));
    check("to_served", 32'(served), 32'd0);
    @(negedge clk);
    check("to_fault_end", 32'(fault), 32'd0);
    m_last = cur_id;
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; dbl_req = 4'b0000; wash_done_in = 1'b0;
    m_last = 2'd3; m_cnt = 8'd0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_cnt", 32'(served_cnt), 32'd0);
    rst = 1'b0;

    // All stations requesting: 0,1,2,3 then 0 again, one IDLE cycle between.
    for (int w = 0; w < 5; w++) begin
      begin_wash(4'b1111, 4'b0000, (w < 4));
      finish_wash(1);
    end

    // Single station with double wash.
    begin_wash(4'b0100, 4'b0100, 1'b0);
    finish_wash(3);

    // Controller never drops done: ACK timeout.
    fault_wash(4'b1000);

    // Reset in RUN aborts the wash and restores station-0 priority.
    begin_wash(4'b0010, 4'b0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("rst_run");
    check("rst_run_cnt", 32'(served_cnt), 32'd0);
    m_last = 2'd3; m_cnt = 8'd0;
    begin_wash(4'b1111, 4'b0000, 1'b0);
    check("rst_regrant", 32'(grant), 32'd1);
    finish_wash(0);

    // Sole requester re-granted every time; dbl_req of idle stations ignored.
    for (int g = 0; g < 300 && m_cnt != 8'hFF; g++) begin
      begin_wash(4'b0010, 4'b1101, 1'b0);
      finish_wash(0);
    end
    begin_wash(4'b0010, 4'b1101, 1'b0);
    finish_wash(0);
    check("cnt_wrap", 32'(served_cnt), 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
